// File: rtl/cons_list_reader.sv
// rtl/cons_list_reader.sv - walks a cons-cell list through the memory read port and streams each cell
module cons_list_reader #(
   parameter logic [15:0] NilPtr        = 16'h0000,
   parameter int          MaxLen        = 256,
   parameter int          TimeoutCycles = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] head_ptr,
   output logic        busy,
   output logic        finish,
   output logic [1:0]  error_code,
   output logic [15:0] count,
   output logic        elem_valid,
   input  logic        elem_ready,
   output logic [15:0] elem_addr,
   output logic [14:0] elem_header,
   output logic [15:0] elem_car,
   output logic        mem_read_enable,
   output logic [15:0] mem_addr,
   input  logic [14:0] mem_header,
   input  logic [15:0] mem_car,
   input  logic [15:0] mem_cdr,
   input  logic        mem_done
);

   localparam int TW = $clog2(TimeoutCycles + 1);

   // Compare against the last count before the counter would reach TimeoutCycles,
   // so the abort happens on exactly the TimeoutCycles-th empty WAIT cycle.
   localparam logic [TW-1:0] TLAST   = TW'(TimeoutCycles - 1);
   localparam logic [15:0]   MAX_LEN = 16'(MaxLen);

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_TOO_LONG = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EMIT,
      FINISH
   } state_t;

   state_t         state;
   logic [15:0]    cur_ptr;
   logic [15:0]    cdr_q;
   logic [TW-1:0]  tcnt;

   // Walk FSM; every output is registered and set on the transition into the state that owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cur_ptr         <= '0;
         cdr_q           <= '0;
         tcnt            <= '0;
         busy            <= 1'b0;
         finish          <= 1'b0;
         error_code      <= ERR_OK;
         count           <= '0;
         elem_valid      <= 1'b0;
         elem_addr       <= '0;
         elem_header     <= '0;
         elem_car        <= '0;
         mem_read_enable <= 1'b0;
         mem_addr        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count      <= '0;
                  error_code <= ERR_OK;
                  if (head_ptr == NilPtr) begin
                     // Empty list: report completion without touching memory.
                     state  <= FINISH;
                     finish <= 1'b1;
                  end else begin
                     state           <= ISSUE;
                     cur_ptr         <= head_ptr;
                     busy            <= 1'b1;
                     mem_read_enable <= 1'b1;
                     mem_addr        <= head_ptr;
                  end
               end
            end

            ISSUE: begin
               // The read request is a single-cycle pulse; the address stays put through WAIT.
               mem_read_enable <= 1'b0;
               tcnt            <= '0;
               state           <= WAIT;
            end

            WAIT: begin
               if (mem_done) begin
                  cdr_q       <= mem_cdr;
                  count       <= count + 16'd1;
                  elem_valid  <= 1'b1;
                  elem_addr   <= cur_ptr;
                  elem_header <= mem_header;
                  elem_car    <= mem_car;
                  state       <= EMIT;
               end else if (tcnt == TLAST) begin
                  error_code <= ERR_TIMEOUT;
                  busy       <= 1'b0;
                  finish     <= 1'b1;
                  state      <= FINISH;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            EMIT: begin
               if (elem_ready) begin
                  elem_valid <= 1'b0;
                  if (cdr_q == NilPtr) begin
                     error_code <= ERR_OK;
                     busy       <= 1'b0;
                     finish     <= 1'b1;
                     state      <= FINISH;
                  end else if (count == MAX_LEN) begin
                     // Cycle guard: a list this long is treated as circular.
                     error_code <= ERR_TOO_LONG;
                     busy       <= 1'b0;
                     finish     <= 1'b1;
                     state      <= FINISH;
                  end else begin
                     cur_ptr         <= cdr_q;
                     mem_read_enable <= 1'b1;
                     mem_addr        <= cdr_q;
                     state           <= ISSUE;
                  end
               end
            end

            FINISH: begin
               finish <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
